piso_shift_tx: RTL and testbench

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/piso_shift_tx.sv | 88 ++++++++
 tb/tb_piso_shift_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready
// handshake and emits it one bit per cycle, LSB-first or MSB-first per the latched sel.
module piso_shift_tx #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             sel,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             sel_q;
    logic             hs;

    assign hs = load_valid && load_ready;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            sel_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                sreg  <= din;
                sel_q <= sel;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                // sel_q=1 drains from bit 0, so move toward the LSB
                sreg <= sel_q ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
                // hold at the last index so the counter never wraps
                if (cnt != LAST)
                    cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                sout_valid = 1'b1;
                busy       = 1'b1;
                sout       = sel_q ? sreg[0] : sreg[WIDTH-1];
                if (cnt == LAST)
                    state_nxt = DONE;
            end
            DONE: begin
                load_ready = 1'b1;
                done       = 1'b1;
                state_nxt  = load_valid ? SHIFT : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: a cycle timeline of expected outputs is queued per accepted
// frame and a negedge monitor compares every cycle against it.
module tb_piso_shift_tx;

    localparam int W = 8;
    localparam int IDLE_ITEM = 3;
    localparam int DONE_ITEM = 2;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         sel = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready, sout, sout_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    bit started = 0;
    int exp_q[$];

    piso_shift_tx #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .din(din), .sel(sel), .load_valid(load_valid),
        .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid),
        .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: the block is ready exactly when no frame timeline is pending.
    // An accepted word schedules WIDTH bit-cycles followed by one done cycle.
    always @(posedge Clk) begin
        if (!Rst_n) begin
            exp_q.delete();
            started = 1;
        end else if (load_valid && exp_q.size() == 0) begin
            for (int i = 0; i < W; i++)
                exp_q.push_back(sel ? int'(din[i]) : int'(din[W-1-i]));
            exp_q.push_back(DONE_ITEM);
            hs_cnt++;
        end
    end

    always @(negedge Clk) begin
        int item;
        if (started) begin
            item = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_ITEM;
            chk("sout_valid", sout_valid, item < 2);
            chk("sout", sout, item == 1);
            chk("busy", busy, item < 2);
            chk("done", done, item == DONE_ITEM);
            chk("load_ready", load_ready, !(item < 2));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic s, input bit hold);
        int n0 = hs_cnt;
        int t = 0;
        load_valid = 1'b1;
        din = d;
        sel = s;
        do begin
            tick();
            t++;
        end while (hs_cnt == n0 && t < 200);
        if (hs_cnt == n0) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: no accept of %h after %0d cycles", d, t);
        end
        if (!hold)
            load_valid = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        Rst_n = 1'b1;
        repeat (2) tick();

        // MSB-first and LSB-first reference words
        send(8'hC1, 1'b0, 0);
        din = 8'h5A; sel = 1'b1;
        repeat (W + 3) tick();
        send(8'hC1, 1'b1, 0);
        repeat (W + 3) tick();

        // back-to-back with load_valid held
        send(8'hFF, 1'b0, 1);
        send(8'h00, 1'b1, 0);
        repeat (W + 3) tick();

        // a pulse during SHIFT must be ignored
        send(8'hC1, 1'b0, 0);
        repeat (2) tick();
        load_valid = 1'b1; din = 8'h3C; sel = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (W + 3) tick();

        // reset mid-frame after bit 3
        send(8'hA5, 1'b1, 0);
        repeat (3) tick();
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        repeat (4) tick();

        // reset wins over a coincident handshake
        Rst_n = 1'b0; load_valid = 1'b1; din = 8'hAA; sel = 1'b0;
        tick();
        Rst_n = 1'b1; load_valid = 1'b0;
        repeat (4) tick();

        // randomized traffic
        for (int f = 0; f < 40; f++) begin
            send(W'($urandom), 1'(($urandom)), ($urandom_range(0, 2) == 0));
            if (!load_valid) begin
                din = W'($urandom);
                sel = 1'(($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    tick();
                    load_valid = 1'b1;
                    tick();
                    load_valid = 1'b0;
                end
                repeat ($urandom_range(0, W + 2)) tick();
            end
        end
        load_valid = 1'b0;
        repeat (W + 4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
